// File: rtl/echo_unit.sv
// Single-tap echo/delay engine: circular RAM buffer, run-time delay, attenuation shift, feedback/feedforward.
// Define ECHO_UNIT_SAT_EN to saturate the output; otherwise the output wraps in two's complement.
//
// state | meaning
// CLEAR | zero one buffer entry per cycle, DEPTH cycles total
// IDLE  | ready for a sample or a flush request
// READ  | registered read of the delayed history entry
// CALC  | form output, write history, advance write pointer
module echo_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int SHIFT_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic [ADDR_W-1:0]        delay_len,
    input  logic [SHIFT_W-1:0]       atten_shift,
    input  logic                     feedforward,
    input  logic                     enable,
    input  logic                     flush,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     clear_busy,
    output logic                     overrun
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_READ, ST_CALC} state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          clr_addr;
    logic signed [DATA_W-1:0]   x_q;
    logic [ADDR_W-1:0]          d_q;
    logic [SHIFT_W-1:0]         s_q;
    logic                       ff_q;
    logic                       en_q;

    logic [DATA_W-1:0]          mem [DEPTH];
    logic signed [DATA_W-1:0]   rd_data;
    logic [ADDR_W-1:0]          rd_addr;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_waddr;
    logic [DATA_W-1:0]          mem_wdata;

    logic signed [DATA_W-1:0]   echo_d;
    logic signed [DATA_W:0]     sum;
    logic signed [DATA_W-1:0]   y_lim;

    assign rd_addr = wr_ptr - d_q;

    always_comb begin
        echo_d = rd_data >>> s_q;
        sum    = {x_q[DATA_W-1], x_q};
        if (en_q) begin
            sum = sum + {echo_d[DATA_W-1], echo_d};
        end
`ifdef ECHO_UNIT_SAT_EN
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            y_lim = sum[DATA_W] ? MIN_V : MAX_V;
        end else begin
            y_lim = sum[DATA_W-1:0];
        end
`else
        y_lim = sum[DATA_W-1:0];
`endif
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        mem_wdata = '0;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
        end else if (state == ST_CALC) begin
            mem_we    = 1'b1;
            mem_wdata = ff_q ? x_q : y_lim;
        end
    end

    // Buffer contents are deliberately not reset; CLEAR zeroes them after reset release.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (state == ST_READ) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_CLEAR;
            wr_ptr     <= '0;
            clr_addr   <= '0;
            in_ready   <= 1'b0;
            clear_busy <= 1'b1;
            out_valid  <= 1'b0;
            out_sample <= '0;
            overrun    <= 1'b0;
            x_q        <= '0;
            d_q        <= ADDR_W'(1);
            s_q        <= '0;
            ff_q       <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == '1) begin
                        state      <= ST_IDLE;
                        in_ready   <= 1'b1;
                        clear_busy <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (flush) begin
                        // A sample offered alongside flush is dropped and flagged.
                        state      <= ST_CLEAR;
                        clr_addr   <= '0;
                        wr_ptr     <= '0;
                        in_ready   <= 1'b0;
                        clear_busy <= 1'b1;
                        if (in_valid) begin
                            overrun <= 1'b1;
                        end
                    end else if (in_valid) begin
                        x_q      <= in_sample;
                        d_q      <= (delay_len == '0) ? ADDR_W'(1) : delay_len;
                        s_q      <= atten_shift;
                        ff_q     <= feedforward;
                        en_q     <= enable;
                        in_ready <= 1'b0;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    out_sample <= y_lim;
                    out_valid  <= 1'b1;
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                    in_ready   <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: doc/echo_unit.md
Name: echo_unit

Overview:
- Parametrised successor to the fixed single-tap echo path in the DSP subsystem.
- Single-tap echo/delay engine with a RAM-backed circular buffer, run-time delay length, attenuation shift, and feedback/feedforward mode.
- Runs on the system clock with a per-sample valid/ready handshake instead of a dedicated sample clock.
- Sits between the codec sample interface and the output mux, alongside the FIR path.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- ADDR_W, 10: buffer address width; DEPTH = 2**ADDR_W entries.
- SHIFT_W, 4: width of the attenuation shift control.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample strobe.
- in_ready  out  1  high only in IDLE; a sample is accepted when in_valid && in_ready.
- in_sample  in  DATA_W  signed input sample.
- delay_len  in  ADDR_W  echo delay D in samples; 0 is treated as 1.
- atten_shift  in  SHIFT_W  arithmetic right shift s applied to the delayed sample.
- feedforward  in  1  0 = store output (recirculating echo); 1 = store input (single echo).
- enable  in  1  0 = bypass: output equals input, but history is still written.
- flush  in  1  one-cycle pulse in IDLE starts a buffer clear.
- out_valid  out  1  one-cycle pulse when out_sample is updated.
- out_sample  out  DATA_W  signed result; held between pulses.
- clear_busy  out  1  high while the buffer is being zeroed.
- overrun  out  1  sticky flag: in_valid asserted while in_ready was low.

Behaviour:
- Reset asserted (reset=0), all asynchronous:
  - out_sample=0, out_valid=0, overrun=0, in_ready=0.
  - Write pointer = 0, FSM = CLEAR.
  - Buffer RAM contents are not reset directly.
- FSM states: CLEAR -> IDLE -> READ -> CALC -> IDLE.
- CLEAR:
  - Writes 0 to addresses 0..DEPTH-1, one per cycle.
  - clear_busy=1, in_ready=0, lasting exactly DEPTH cycles, then goes to IDLE.
  - Entered after reset release, or from IDLE on flush=1.
  - flush is ignored in every other state.
  - A flush clear also resets the write pointer to 0; overrun is unaffected.
- IDLE:
  - in_ready=1.
  - On acceptance, latch in_sample, delay_len (0 -> 1), atten_shift, feedforward and enable, then go to READ.
  - Changes to these controls mid-sample have no effect until the next accepted sample.
  - flush and in_valid in the same cycle: flush wins, the sample is dropped and overrun is set.
- READ: read address = (wr_ptr - D) mod DEPTH; the RAM read is registered.
- CALC:
  - d = rd_data >>> s (arithmetic; s >= DATA_W yields 0 or -1 by sign).
  - y = enable ? in + d : in, computed at DATA_W+1 bits, then limited to DATA_W (see the optional feature).
  - out_sample <= y, out_valid pulses.
  - RAM[wr_ptr] <= (feedforward ? in : y).
  - wr_ptr increments mod DEPTH (wraps DEPTH-1 -> 0); return to IDLE.
- Latency: out_valid is high in the 3rd cycle after the accepting edge. Maximum throughput is 1 sample per 3 clocks.
- Transfer function, per accepted sample n:
  - Feedforward: y[n] = x[n] + (x[n-D] >>> s).
  - Feedback: y[n] = x[n] + (y[n-D] >>> s).
  - History before a clear reads as 0.
- Overrun: set when in_valid=1 and in_ready=0 (including during CLEAR). The sample is discarded. Cleared only by reset.
- D = DEPTH-1 is the maximum; read and write addresses never collide within one sample.
- Reset asserted mid-sample aborts the operation: no out_valid, and a fresh CLEAR runs after release.

Optional Feature:
- Macro: ECHO_UNIT_SAT_EN.
- Defined: y saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1], i.e. 32767/-32768 for DATA_W=16.
- Undefined: y wraps (two's complement, truncated to DATA_W bits).
- The stored feedback value equals the limited y in both builds.

Test Plan:
Bench parameters: DATA_W=16, ADDR_W=4.
- Reset release -> clear_busy high exactly 16 cycles, in_ready=0 throughout; then in_ready=1 and out_sample=0.
- Feedforward=1, D=3, s=1: impulse 1000 then zeros -> outputs 1000,0,0,500,0,0...; each out_valid exactly 3 cycles after acceptance.
- Feedforward=0, D=2, s=1: impulse 1024 -> 1024,0,512,0,256,0,128...; D=15 with 20 samples checks pointer wrap, echo at sample index 15.
- Saturation:
  - SAT_EN build, feedforward=1, D=1, s=0, samples 30000,30000 -> 30000,32767.
  - Same stimulus without the macro -> 30000,-5536.
  - Input -32768 twice -> -32768 (SAT_EN) / 0 (wrap).
- in_valid held high continuously -> one sample accepted every 3 clocks; overrun sets on the first cycle in_valid is high with in_ready=0.
- enable=0 with feedforward=0, D=1: 100,200 -> 100,200; then enable=1, s=0, sample 5 -> 205.
- flush in IDLE -> 16-cycle clear, after which a D=1 echo reads 0.
- reset pulled low during READ -> no out_valid, and a full 16-cycle CLEAR follows release.
